cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Cache controller FSM for the set-associative cache. It sits directly upstream of the tag memory and drives its addr/wr/md inputs. It consumes the tag memory's hit/chan/tegOut outputs.
- Sequences CPU requests (hit service, dirty-victim writeback, line fill, tag allocate, replay) across the CPU port, the data array and external memory.

Parameters:
- ATEG_WIDTH, 7, tag bits of address
- AINDEX_WIDTH, 6, set index bits
- CHANNEL_WIDTH, 3, log2 of number of ways
- WORD_WIDTH, 2, log2 of words per line
- DATA_WIDTH, 32, CPU/memory word width

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  synchronous active-low reset
- cpu_req  in  1  request strobe, sampled only in IDLE
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ATEG_WIDTH+AINDEX_WIDTH+WORD_WIDTH  {tag,index,word}
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_rdata  out  DATA_WIDTH  read data, registered
- cpu_ready  out  1  one-cycle completion pulse
- tm_addr  out  ATEG_WIDTH+AINDEX_WIDTH  {tag,index} to tag memory
- tm_wr  out  1  allocate tag into selected way
- tm_md  out  1  mark selected way dirty
- tm_teg  in  ATEG_WIDTH+2  {valid,dirty,tag} of selected way
- tm_chan  in  CHANNEL_WIDTH  selected way (hit way, else replacement way)
- tm_hit  in  1  tag hit (combinational from tm_addr)
- da_addr  out  CHANNEL_WIDTH+AINDEX_WIDTH+WORD_WIDTH  {way,index,word}
- da_we  out  1  data array write enable
- da_wdata  out  DATA_WIDTH  data array write data
- da_rdata  in  DATA_WIDTH  data array asynchronous read data
- mem_req  out  1  memory burst active
- mem_we  out  1  1=writeback burst, 0=fill burst
- mem_addr  out  ATEG_WIDTH+AINDEX_WIDTH  line address {tag,index}
- mem_wdata  out  DATA_WIDTH  writeback beat data
- mem_rdata  in  DATA_WIDTH  fill beat data
- mem_ack  in  1  beat accepted/valid; one per cycle max

Behaviour:
- Reset (reset_n=0 at edge, any state, including mid-burst):
  - state=IDLE; word counter=0.
  - cpu_ready, cpu_rdata, tm_wr, tm_md, da_we, mem_req and mem_we all go to 0.
  - The tag memory resets on the same reset_n.
- Request latching: in IDLE, cpu_req=1 latches addr/we/wdata into request registers. cpu_req is ignored in every other state.
- tm_addr source: cpu_addr tag/index in IDLE, latched request otherwise.
- States:
  - IDLE: wait for cpu_req, then -> LOOKUP.
  - LOOKUP (1 cycle): register tm_hit, tm_chan and tm_teg as way, valid (bit ATEG_WIDTH+1), dirty (bit ATEG_WIDTH) and victim tag. Then:
    - hit & read -> RD
    - hit & write -> WR
    - miss & valid & dirty -> WB
    - miss otherwise -> FILL
  - RD (1 cycle): da_addr={way,index,word}; cpu_rdata<=da_rdata; cpu_ready=1; -> IDLE.
  - WR (1 cycle): da_we=1, da_wdata=req wdata; tm_md=1; cpu_ready=1; -> IDLE.
  - WB:
    - mem_req=1, mem_we=1, mem_addr={victim tag,index}.
    - da_addr={way,index,cnt}; mem_wdata=da_rdata.
    - Each mem_ack increments cnt. The ack with cnt=2**WORD_WIDTH-1 wraps cnt to 0 and -> FILL.
  - FILL:
    - mem_req=1, mem_we=0, mem_addr={req tag,index}.
    - Each mem_ack: da_we=1, da_addr={way,index,cnt}, da_wdata=mem_rdata, cnt++.
    - Last ack wraps cnt and -> ALLOC.
  - ALLOC (1 cycle): tm_wr=1 (tag memory writes the tag into tm_chan = replacement way and advances its replacement pointer); tm_md=0; -> LOOKUP (replay, now hits).
- mem_req stays high for the whole burst, including cycles with mem_ack=0 (stall). cnt holds while mem_ack=0.
- Way stability: tm_chan must equal the latched way during WB/FILL/ALLOC. No tm_wr occurs between LOOKUP and ALLOC, so the replacement pointer is frozen.
- Strobes: tm_wr, tm_md, da_we and cpu_ready are single-cycle pulses and are never asserted together except tm_md with da_we in WR.
- cpu_rdata holds its value until the next RD.
- Latency from cpu_req cycle (no stalls, N=2**WORD_WIDTH):
  - hit: cpu_ready at +2
  - clean miss: +N+5
  - dirty miss: +2N+5

Test Plan:
- Reset, then read 0x0000, mem_ack tied high, mem_rdata=beat index+0x100 -> 4 fill beats with mem_we=0 and mem_addr=0, one tm_wr pulse, cpu_ready at cycle +9, cpu_rdata=0x100.
- Read 0x0002 after previous -> hit, no mem_req, cpu_ready at +2, cpu_rdata=0x102.
- Write 0x0001 data 0xDEADBEEF on hit -> da_we and tm_md pulse together, ready at +2; subsequent read of 0x0001 returns 0xDEADBEEF.
- Fill all 8 ways of index 0 (tags 0..7), dirty way 0, then read tag 8 index 0:
  - writeback burst mem_we=1 to mem_addr {0,0} with beat1=0xDEADBEEF;
  - then fill of {8,0};
  - ready at +13.
- Fill with mem_ack low 3 cycles between beats -> mem_req held, cnt frozen, data written only on ack cycles, correct cpu_rdata.
- Assert reset_n=0 during FILL beat 2 -> next cycle IDLE, mem_req=0, no tm_wr; a new request afterwards misses and fills normally.

Source files
------------

// File: rtl/cache_ctrl.sv
// Set-associative cache controller: sequences hits, dirty writeback, line fill,
// tag allocation and replay between the CPU, tag memory, data array and memory.
module cache_ctrl #(
  parameter int ATEG_WIDTH    = 7,
  parameter int AINDEX_WIDTH  = 6,
  parameter int CHANNEL_WIDTH = 3,
  parameter int WORD_WIDTH    = 2,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        cpu_req,
  input  logic                                        cpu_we,
  input  logic [ATEG_WIDTH+AINDEX_WIDTH+WORD_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]                       cpu_wdata,
  output logic [DATA_WIDTH-1:0]                       cpu_rdata,
  output logic                                        cpu_ready,
  output logic [ATEG_WIDTH+AINDEX_WIDTH-1:0]          tm_addr,
  output logic                                        tm_wr,
  output logic                                        tm_md,
  input  logic [ATEG_WIDTH+1:0]                       tm_teg,
  input  logic [CHANNEL_WIDTH-1:0]                    tm_chan,
  input  logic                                        tm_hit,
  output logic [CHANNEL_WIDTH+AINDEX_WIDTH+WORD_WIDTH-1:0] da_addr,
  output logic                                        da_we,
  output logic [DATA_WIDTH-1:0]                       da_wdata,
  input  logic [DATA_WIDTH-1:0]                       da_rdata,
  output logic                                        mem_req,
  output logic                                        mem_we,
  output logic [ATEG_WIDTH+AINDEX_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]                       mem_wdata,
  input  logic [DATA_WIDTH-1:0]                       mem_rdata,
  input  logic                                        mem_ack
);

  localparam int AW = ATEG_WIDTH + AINDEX_WIDTH + WORD_WIDTH;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, RD, WR, WB, FILL, ALLOC
  } state_t;

  state_t                    state;
  logic [WORD_WIDTH-1:0]     cnt;
  logic                      req_we;
  logic [ATEG_WIDTH-1:0]     req_tag;
  logic [AINDEX_WIDTH-1:0]   req_index;
  logic [WORD_WIDTH-1:0]     req_word;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [CHANNEL_WIDTH-1:0]  way;
  logic [ATEG_WIDTH-1:0]     victim_tag;
  logic                      beat;

  assign beat = mem_req && mem_ack;

  // mem_req rises one cycle after a burst state is entered (request setup
  // cycle) and stays high across the WB->FILL hand-over; acks count only
  // while it is already high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      req_we     <= 1'b0;
      req_tag    <= '0;
      req_index  <= '0;
      req_word   <= '0;
      req_wdata  <= '0;
      way        <= '0;
      victim_tag <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_tag   <= cpu_addr[AW-1:AINDEX_WIDTH+WORD_WIDTH];
            req_index <= cpu_addr[AINDEX_WIDTH+WORD_WIDTH-1:WORD_WIDTH];
            req_word  <= cpu_addr[WORD_WIDTH-1:0];
            req_wdata <= cpu_wdata;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          way        <= tm_chan;
          victim_tag <= tm_teg[ATEG_WIDTH-1:0];
          if (tm_hit) begin
            state <= req_we ? WR : RD;
          end else if (tm_teg[ATEG_WIDTH+1] && tm_teg[ATEG_WIDTH]) begin
            mem_we <= 1'b1;
            state  <= WB;
          end else begin
            mem_we <= 1'b0;
            state  <= FILL;
          end
        end
        RD: begin
          cpu_rdata <= da_rdata;
          state     <= IDLE;
        end
        WR: state <= IDLE;
        WB: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
              mem_we <= 1'b0;
              state  <= FILL;
            end
          end
        end
        FILL: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
              mem_req <= 1'b0;
              state   <= ALLOC;
            end
          end
        end
        ALLOC: state <= LOOKUP;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tm_addr   = (state == IDLE) ? cpu_addr[AW-1:WORD_WIDTH] : {req_tag, req_index};
    cpu_ready = (state == RD) || (state == WR);
    tm_wr     = (state == ALLOC);
    tm_md     = (state == WR);
    da_we     = (state == WR) || ((state == FILL) && beat);
    da_wdata  = (state == FILL) ? mem_rdata : req_wdata;
    da_addr   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      RD, WR:   da_addr = {way, req_index, req_word};
      WB: begin
        da_addr   = {way, req_index, cnt};
        mem_addr  = {victim_tag, req_index};
        mem_wdata = da_rdata;
      end
      FILL: begin
        da_addr  = {way, req_index, cnt};
        mem_addr = {req_tag, req_index};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with behavioural tag memory, data array and
// burst memory; expected latencies and data are hand-computed constants.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [12:0] tm_addr;
  logic        tm_wr;
  logic        tm_md;
  logic [8:0]  tm_teg;
  logic [2:0]  tm_chan;
  logic        tm_hit;
  logic [10:0] da_addr;
  logic        da_we;
  logic [31:0] da_wdata;
  logic [31:0] da_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  always #5 clk = ~clk;

  cache_ctrl #(
    .ATEG_WIDTH(7), .AINDEX_WIDTH(6), .CHANNEL_WIDTH(3), .WORD_WIDTH(2), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .tm_addr(tm_addr), .tm_wr(tm_wr), .tm_md(tm_md), .tm_teg(tm_teg),
    .tm_chan(tm_chan), .tm_hit(tm_hit),
    .da_addr(da_addr), .da_we(da_we), .da_wdata(da_wdata), .da_rdata(da_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Tag memory model: 64 sets x 8 ways, round-robin replacement pointer.
  logic        tvalid [64][8];
  logic        tdirty [64][8];
  logic [6:0]  ttag   [64][8];
  logic [2:0]  rptr   [64];
  logic [5:0]  tset;
  logic [6:0]  ttg;

  assign tset = tm_addr[5:0];
  assign ttg  = tm_addr[12:6];

  always_comb begin
    tm_hit  = 1'b0;
    tm_chan = rptr[tset];
    for (int unsigned w = 0; w < 8; w++) begin
      if (tvalid[tset][w] && ttag[tset][w] == ttg) begin
        tm_hit  = 1'b1;
        tm_chan = w[2:0];
      end
    end
    tm_teg = {tvalid[tset][tm_chan], tdirty[tset][tm_chan], ttag[tset][tm_chan]};
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < 64; s++) begin
        rptr[s] <= '0;
        for (int unsigned w = 0; w < 8; w++) begin
          tvalid[s][w] <= 1'b0;
          tdirty[s][w] <= 1'b0;
          ttag[s][w]   <= '0;
        end
      end
    end else begin
      if (tm_wr) begin
        tvalid[tset][tm_chan] <= 1'b1;
        tdirty[tset][tm_chan] <= 1'b0;
        ttag[tset][tm_chan]   <= ttg;
        rptr[tset]            <= rptr[tset] + 3'd1;
      end
      if (tm_md) tdirty[tset][tm_chan] <= 1'b1;
    end
  end

  // Data array model with asynchronous read.
  logic [31:0] dmem [2048];
  assign da_rdata = dmem[da_addr];
  always @(posedge clk) if (da_we) dmem[da_addr] <= da_wdata;

  // Memory model: fill data = 0x100 + beat + (line address << 12).
  logic       stall_mode;
  logic [1:0] mbeat;
  logic [1:0] sph;
  assign mem_ack   = stall_mode ? (mem_req && sph == 2'd3) : 1'b1;
  assign mem_rdata = 32'h100 + {30'b0, mbeat} + ({19'b0, mem_addr} << 12);
  always @(posedge clk) begin
    if (!reset_n || !mem_req) begin
      mbeat <= '0;
      sph   <= '0;
    end else begin
      sph <= sph + 2'd1;
      if (mem_ack) mbeat <= mbeat + 2'd1;
    end
  end

  // Activity monitors (cumulative; tests work on deltas).
  int          n_tmwr = 0, n_fill = 0, n_wb = 0, n_reqcyc = 0, n_both = 0, n_dawe = 0;
  int          n_bad_dawe = 0, n_strobe_bad = 0;
  logic [31:0] wb_data [4];
  logic [12:0] wb_addr, fill_addr;
  always @(posedge clk) begin
    if (reset_n) begin
      if (tm_wr) n_tmwr++;
      if (mem_req) n_reqcyc++;
      if (da_we) n_dawe++;
      if (da_we && tm_md) n_both++;
      if (da_we && !tm_md && !(mem_req && mem_ack)) n_bad_dawe++;
      if ((tm_wr && (tm_md || da_we || cpu_ready)) || (tm_md && !da_we)) n_strobe_bad++;
      if (mem_req && mem_ack) begin
        if (mem_we) begin
          n_wb++;
          wb_data[mbeat] = mem_wdata;
          wb_addr = mem_addr;
        end else begin
          n_fill++;
          fill_addr = mem_addr;
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [14:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (cpu_ready) begin
        lat = k;
        break;
      end
    end
    @(negedge clk);
    rd = cpu_rdata;
  endtask

  int          lat;
  logic [31:0] rd;
  int          b_tmwr, b_fill, b_wb, b_req, b_both, b_dawe;

  task automatic snap();
    b_tmwr = n_tmwr; b_fill = n_fill; b_wb = n_wb;
    b_req = n_reqcyc; b_both = n_both; b_dawe = n_dawe;
  endtask

  initial begin
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    stall_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, cpu_ready}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_strobes", {26'b0, mem_req, mem_we, tm_wr, tm_md, da_we, cpu_ready}, 32'd0);
    reset_n = 1'b1;

    // Clean miss on 0x0000
    snap();
    do_req(1'b0, 15'h0000, '0, lat, rd);
    check("miss_lat", 32'(lat), 32'd9);
    check("miss_rdata", rd, 32'h100);
    check("miss_fill_beats", 32'(n_fill - b_fill), 32'd4);
    check("miss_wb_beats", 32'(n_wb - b_wb), 32'd0);
    check("miss_tmwr", 32'(n_tmwr - b_tmwr), 32'd1);
    check("miss_fill_addr", {19'b0, fill_addr}, 32'd0);

    // Read hit on word 2
    snap();
    do_req(1'b0, 15'h0002, '0, lat, rd);
    check("hit_lat", 32'(lat), 32'd2);
    check("hit_rdata", rd, 32'h102);
    check("hit_no_memreq", 32'(n_reqcyc - b_req), 32'd0);

    // Write hit then read back
    snap();
    do_req(1'b1, 15'h0001, 32'hDEADBEEF, lat, rd);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_da_we_tm_md", 32'(n_both - b_both), 32'd1);
    do_req(1'b0, 15'h0001, '0, lat, rd);
    check("wr_readback", rd, 32'hDEADBEEF);

    // Fill remaining ways 1..7 of index 0
    for (int t = 1; t < 8; t++) begin
      do_req(1'b0, 15'(t << 8), '0, lat, rd);
      check("way_fill_lat", 32'(lat), 32'd9);
      check("way_fill_rdata", rd, 32'h100 + (32'(t) << 18));
    end

    // Tag 8 evicts dirty way 0
    snap();
    do_req(1'b0, 15'h0800, '0, lat, rd);
    check("dirty_lat", 32'(lat), 32'd13);
    check("dirty_wb_beats", 32'(n_wb - b_wb), 32'd4);
    check("dirty_wb_addr", {19'b0, wb_addr}, 32'd0);
    check("dirty_wb_beat0", wb_data[0], 32'h100);
    check("dirty_wb_beat1", wb_data[1], 32'hDEADBEEF);
    check("dirty_wb_beat3", wb_data[3], 32'h103);
    check("dirty_fill_addr", {19'b0, fill_addr}, 32'h200);
    check("dirty_rdata", rd, 32'h0020_0100);

    // Stalled fill: 3 idle cycles between beats
    stall_mode = 1'b1;
    snap();
    do_req(1'b0, 15'h0307, '0, lat, rd);
    check("stall_lat", 32'(lat), 32'd21);
    check("stall_rdata", rd, 32'h000C_1103);
    check("stall_req_cycles", 32'(n_reqcyc - b_req), 32'd16);
    check("stall_da_we", 32'(n_dawe - b_dawe), 32'd4);
    stall_mode = 1'b0;
    do_req(1'b0, 15'h0304, '0, lat, rd);
    check("stall_hit_rdata", rd, 32'h000C_1100);

    // Reset in the middle of a fill burst
    snap();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0508;
    @(negedge clk); cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_burst_active", {31'b0, mem_req}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_idle", {28'b0, mem_req, tm_wr, da_we, cpu_ready}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_stays_idle", {31'b0, mem_req}, 32'd0);
    check("midrst_no_tmwr", 32'(n_tmwr - b_tmwr), 32'd0);
    snap();
    do_req(1'b0, 15'h0508, '0, lat, rd);
    check("postrst_lat", 32'(lat), 32'd9);
    check("postrst_rdata", rd, 32'h0014_2100);
    check("postrst_tmwr", 32'(n_tmwr - b_tmwr), 32'd1);

    check("strobe_exclusive", 32'(n_strobe_bad), 32'd0);
    check("da_we_only_on_ack", 32'(n_bad_dawe), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
